fmul: RTL and testbench

FMUL -- requirements
Module: fmul

---
 rtl/fmul_pkg.sv | 13 +
 rtl/fmul_round.sv | 36 +++
 rtl/fmul.sv | 49 ++++
 tb/tb_fmul.sv | 85 ++++++++
 4 files changed

// File: rtl/fmul_pkg.sv
// fmul_pkg: shared defaults, field widths and exception codes for the FloPoCo multiplier
package fmul_pkg;
  localparam int WE_DEF = 4;
  localparam int WF_DEF = 4;
  localparam int BIAS = (1 << (WE_DEF - 1)) - 1;
  localparam int WIDTH = WE_DEF + WF_DEF + 3;
  typedef enum logic [1:0] {
    EXN_ZERO   = 2'b00,
    EXN_NORMAL = 2'b01,
    EXN_INF    = 2'b10,
    EXN_NAN    = 2'b11
  } exn_e;
endpackage

// File: rtl/fmul_round.sv
// fmul_round: normalise the significand product, round to nearest even, classify exponent range
module fmul_round
  import fmul_pkg::*;
#(
  parameter int WE = WE_DEF,
  parameter int WF = WF_DEF
) (
  input  logic [2*WF+1:0]      prod_i,
  input  logic signed [WE+1:0] exp_i,
  output logic [1:0]           exn_o,
  output logic [WE-1:0]        exp_o,
  output logic [WF-1:0]        frac_o
);
  localparam logic signed [WE+1:0] EMAX = (WE + 2)'((1 << WE) - 1);
  logic msb, g, s, up, ovf, udf;
  logic [2*WF+1:0] norm;
  logic [WF-1:0] fr;
  logic [WF:0] sum;
  logic signed [WE+1:0] ef;
  // bring leading one to the top, round on guard/sticky, fold both carries into the exponent
  always_comb begin
    msb = prod_i[2*WF+1];
    norm = msb ? prod_i : {prod_i[2*WF:0], 1'b0};
    fr = norm[2*WF:WF+1];
    g = norm[WF];
    s = |norm[WF-1:0];
    up = g & (s | fr[0]);
    sum = {1'b0, fr} + {{WF{1'b0}}, up};
    ef = exp_i + $signed({{(WE + 1){1'b0}}, msb}) + $signed({{(WE + 1){1'b0}}, sum[WF]});
    ovf = ef > EMAX;
    udf = ef[WE+1];
    exn_o = ovf ? EXN_INF : udf ? EXN_ZERO : EXN_NORMAL;
    exp_o = (ovf | udf) ? '0 : ef[WE-1:0];
    frac_o = (ovf | udf) ? '0 : sum[WF-1:0];
  end
endmodule

// File: rtl/fmul.sv
// fmul: single-cycle FloPoCo-format floating-point multiplier with registered output
module fmul
  import fmul_pkg::*;
#(
  parameter int WE = WE_DEF,
  parameter int WF = WF_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WE+WF+2:0]   X,
  input  logic [WE+WF+2:0]   Y,
  output logic [WE+WF+2:0]   R
);
  localparam int W = WE + WF + 3;
  localparam int B = (1 << (WE - 1)) - 1;
  logic [1:0] xe, ye, rnd_exn, exn_d;
  logic sgn, nan, inf, zero;
  logic [2*WF+1:0] prod;
  logic signed [WE+1:0] esum;
  logic [WE-1:0] rnd_exp;
  logic [WF-1:0] rnd_frac;
  logic [W-1:0] r_d, r_q;
  assign xe = X[W-1:W-2];
  assign ye = Y[W-1:W-2];
  assign prod = {{(WF + 1){1'b0}}, 1'b1, X[WF-1:0]} * {{(WF + 1){1'b0}}, 1'b1, Y[WF-1:0]};
  assign esum = $signed({2'b00, X[WE+WF-1:WF]}) + $signed({2'b00, Y[WE+WF-1:WF]}) - $signed((WE + 2)'(B));
  fmul_round #(.WE(WE), .WF(WF)) u_round (
    .prod_i(prod),
    .exp_i (esum),
    .exn_o (rnd_exn),
    .exp_o (rnd_exp),
    .frac_o(rnd_frac)
  );
  // exception classes override the rounded normal result; special results carry empty fields
  always_comb begin
    sgn = X[W-3] ^ Y[W-3];
    nan = (xe == EXN_NAN) | (ye == EXN_NAN) | ((xe == EXN_ZERO) & (ye == EXN_INF)) | ((xe == EXN_INF) & (ye == EXN_ZERO));
    inf = (xe == EXN_INF) | (ye == EXN_INF);
    zero = (xe == EXN_ZERO) | (ye == EXN_ZERO);
    exn_d = nan ? EXN_NAN : inf ? EXN_INF : zero ? EXN_ZERO : rnd_exn;
    r_d = (exn_d == EXN_NORMAL) ? {exn_d, sgn, rnd_exp, rnd_frac} : {exn_d, sgn, {(WE + WF){1'b0}}};
  end
  // output register, cleared asynchronously so an in-flight result is dropped on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_q <= '0;
    else r_q <= r_d;
  end
  assign R = r_q;
endmodule

// File: tb/tb_fmul.sv
// tb_fmul: directed-vector bench for fmul at default parameters
module tb_fmul;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [10:0] X = '0;
  logic [10:0] Y = '0;
  logic [10:0] R;
  int tests = 0;
  int fails = 0;

  fmul dut (.clk(clk), .reset(reset), .X(X), .Y(Y), .R(R));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [10:0] exp_r);
    tests++;
    assert (R === exp_r) else begin
      fails++;
      $error("FAIL %s: R=%h expected %h", tag, R, exp_r);
    end
  endtask

  task automatic step(input string tag, input logic [10:0] x, input logic [10:0] y, input logic [10:0] exp_r);
    X = x;
    Y = y;
    @(posedge clk);
    #1;
    check(tag, exp_r);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 check("reset_async", 11'h000);
    X = 11'h280;
    Y = 11'h288;
    @(posedge clk);
    #1 check("reset_held", 11'h000);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 check("first_after_reset", 11'h298);
    step("neg_2x3", 11'h380, 11'h288, 11'h398);
    step("one_x_one", 11'h270, 11'h270, 11'h270);
    step("round_sq", 11'h271, 11'h271, 11'h272);
    step("tie_even_down", 11'h273, 11'h278, 11'h27C);
    step("tie_even_up", 11'h271, 11'h278, 11'h27A);
    step("round_carry", 11'h277, 11'h276, 11'h280);
    step("zero_x_inf", 11'h000, 11'h400, 11'h600);
    step("inf_x_zero", 11'h400, 11'h000, 11'h600);
    step("nan_x_2", 11'h600, 11'h280, 11'h600);
    step("negnan_x_2", 11'h700, 11'h280, 11'h700);
    step("inf_x_3", 11'h400, 11'h288, 11'h400);
    step("inf_junk_fields", 11'h4FF, 11'h288, 11'h400);
    step("negzero_x_3", 11'h100, 11'h288, 11'h100);
    step("zero_junk_fields", 11'h0AB, 11'h288, 11'h000);
    step("ovf_max", 11'h2FF, 11'h2FF, 11'h400);
    step("ovf_neg", 11'h3FF, 11'h2FF, 11'h500);
    step("ovf_edge", 11'h2F8, 11'h288, 11'h400);
    step("emax_ok", 11'h2F0, 11'h278, 11'h2F8);
    step("udf_min", 11'h200, 11'h200, 11'h000);
    step("emin_ok", 11'h200, 11'h270, 11'h200);
    step("udf_edge", 11'h200, 11'h260, 11'h000);
    step("udf_neg", 11'h300, 11'h260, 11'h100);
    step("wide_range", 11'h200, 11'h2F0, 11'h280);
    #2 reset = 1'b0;
    #1 check("reset_midstream", 11'h000);
    X = 11'h288;
    Y = 11'h288;
    @(posedge clk);
    #1 check("reset_discard", 11'h000);
    #2 reset = 1'b1;
    step("b2b_0", 11'h280, 11'h288, 11'h298);
    step("b2b_1", 11'h271, 11'h271, 11'h272);
    step("b2b_2", 11'h380, 11'h288, 11'h398);
    step("b2b_3", 11'h2FF, 11'h2FF, 11'h400);
    step("b2b_4", 11'h273, 11'h278, 11'h27C);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
